// File: rtl/fb_pixel_writer.sv
// Frame-buffer pixel writer: buffers painted pixels in a small FIFO and writes each one
// to the frame-buffer RAM at its row-major address through a req/gnt arbiter.
module fb_pixel_writer #(
  parameter int X_W        = 6,
  parameter int Y_W        = 6,
  parameter int DATA_W     = 8,
  parameter int FB_COLS    = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              paint,
  input  logic [DATA_W-1:0] px_data,
  input  logic [X_W-1:0]    in_x,
  input  logic [Y_W-1:0]    in_y,
  input  logic              clr_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              full,
  output logic              idle,
  output logic              overflow,
  output logic              oob
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              full_q, full_d;
  logic              idle_q, idle_d;
  logic              overflow_q, overflow_d;
  logic              oob_q, oob_d;

  logic              x_in_range;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              load_head;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    x_in_range = 32'(in_x) < 32'(FB_COLS);
    fifo_full  = count_q == CNT_W'(FIFO_DEPTH);
    push       = paint && x_in_range && !fifo_full;
    pop        = state_q == S_WRITE;
    // Multiply at full width, then keep only the low ADDR_W bits.
    push_addr  = ADDR_W'(32'(in_y) * 32'(FB_COLS) + 32'(in_x));

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (mem_gnt) state_d = S_WRITE;
      S_WRITE: state_d = (count_d != '0) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The next head may be the entry being pushed on this very edge.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_addr = push_addr;
      head_data = px_data;
    end else begin
      head_addr = addr_mem[rd_ptr_d];
      head_data = data_mem[rd_ptr_d];
    end

    load_head   = (state_d == S_REQ) && (state_q != S_REQ);
    mem_addr_d  = load_head ? head_addr : mem_addr_q;
    mem_wdata_d = load_head ? head_data : mem_wdata_q;

    mem_req_d  = state_d != S_IDLE;
    mem_we_d   = state_d == S_WRITE;
    full_d     = count_d == CNT_W'(FIFO_DEPTH);
    idle_d     = (count_d == '0) && (state_d == S_IDLE);
    overflow_d = (paint && x_in_range && fifo_full) || (overflow_q && !clr_err);
    oob_d      = (paint && !x_in_range) || (oob_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= px_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      full_q      <= 1'b0;
      idle_q      <= 1'b1;
      overflow_q  <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      full_q      <= full_d;
      idle_q      <= idle_d;
      overflow_q  <= overflow_d;
      oob_q       <= oob_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = full_q;
  assign idle      = idle_q;
  assign overflow  = overflow_q;
  assign oob       = oob_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a 12-bit-address instance plus a 10-bit-address
// instance driven by the same stimulus, with a write monitor feeding per-instance logs.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        paint;
  logic [7:0]  px_data;
  logic [6:0]  in_x;
  logic [5:0]  in_y;
  logic        clr_err;
  logic        mem_gnt;

  logic        mem_req, mem_we, full, idle, overflow, oob;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req2, mem_we2, full2, idle2, overflow2, oob2;
  logic [9:0]  mem_addr2;
  logic [7:0]  mem_wdata2;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  gnt_toggle = 1'b0;

  logic [11:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  logic [9:0]  wq2_addr[$];
  logic [11:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  fb_pixel_writer #(.X_W(7), .Y_W(6), .DATA_W(8), .FB_COLS(64), .ADDR_W(12), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .paint(paint), .px_data(px_data), .in_x(in_x), .in_y(in_y),
    .clr_err(clr_err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full), .idle(idle),
    .overflow(overflow), .oob(oob)
  );

  fb_pixel_writer #(.X_W(7), .Y_W(6), .DATA_W(8), .FB_COLS(64), .ADDR_W(10), .FIFO_DEPTH(4)) u_dut10 (
    .clk(clk), .rst(rst), .paint(paint), .px_data(px_data), .in_x(in_x), .in_y(in_y),
    .clr_err(clr_err), .mem_req(mem_req2), .mem_gnt(mem_gnt), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .full(full2), .idle(idle2),
    .overflow(overflow2), .oob(oob2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      $display("[TB] write addr=%0d data=%02h", mem_addr, mem_wdata);
    end
    if (mem_we2 === 1'b1) wq2_addr.push_back(mem_addr2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gnt_toggle) mem_gnt = (cyc % 3 == 0);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (idle === 1'b1 && mem_req === 1'b0) break;
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic drive_px(input int x, input int y, input logic [7:0] d);
    paint   = 1'b1;
    in_x    = 7'(x);
    in_y    = 6'(y);
    px_data = d;
  endtask

  initial begin
    int base;
    rst = 1'b1; paint = 1'b0; clr_err = 1'b0; mem_gnt = 1'b0;
    px_data = '0; in_x = '0; in_y = '0;
    repeat (3) tick();
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_full", full, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf", overflow, 0);
    check("rst_oob", oob, 0);
    rst = 1'b0;
    tick();

    // Single pixel with grant tied high: addr 2*64+3.
    mem_gnt = 1'b1;
    drive_px(3, 2, 8'hA5);
    tick();
    paint = 1'b0;
    check("t1_idle_drop", idle, 0);
    check("t1_req_e0", mem_req, 0);
    tick();
    check("t1_req_e1", mem_req, 1);
    check("t1_we_e1", mem_we, 0);
    check("t1_addr_e1", mem_addr, 131);
    check("t1_data_e1", mem_wdata, 8'hA5);
    tick();
    check("t1_we_e2", mem_we, 1);
    check("t1_addr_e2", mem_addr, 131);
    check("t1_data_e2", mem_wdata, 8'hA5);
    tick();
    check("t1_we_e3", mem_we, 0);
    check("t1_req_e3", mem_req, 0);
    check("t1_idle_e3", idle, 1);
    check("t1_nwrites", wq_addr.size(), 1);

    // Six paints with no grant: four kept, two dropped.
    wq_addr.delete(); wq_data.delete();
    mem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_px(i, 1, 8'h10 + 8'(i));
      tick();
      if (i == 3) begin
        check("t2_full_4", full, 1);
        check("t2_ovf_4", overflow, 0);
      end
    end
    paint = 1'b0;
    check("t2_ovf", overflow, 1);
    check("t2_full", full, 1);
    check("t2_req_wait", mem_req, 1);
    check("t2_no_we", mem_we, 0);
    check("t2_nwr_nognt", wq_addr.size(), 0);
    mem_gnt = 1'b1;
    wait_idle("t2_drain_idle", 40);
    check("t2_nwrites", wq_addr.size(), 4);
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      check($sformatf("t2_addr%0d", i), wq_addr[i], 64 + i);
      check($sformatf("t2_data%0d", i), wq_data[i], 8'h10 + i);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // Out-of-range column.
    base = wq_addr.size();
    drive_px(64, 0, 8'h77);
    tick();
    paint = 1'b0;
    check("t3_oob", oob, 1);
    check("t3_idle", idle, 1);
    check("t3_ovf", overflow, 0);
    repeat (3) tick();
    check("t3_nowrite", wq_addr.size(), base);
    clr_err = 1'b1;
    drive_px(100, 3, 8'h01);
    tick();
    paint = 1'b0;
    clr_err = 1'b0;
    check("t3_oob_wins", oob, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_oob_clr", oob, 0);

    // Bursts of four with grant high one cycle in three.
    wq_addr.delete(); wq_data.delete();
    gnt_toggle = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive_px(r * 17 + i * 5, r * 7 + i * 3 + 1, 8'h30 + 8'(r * 16 + i));
        exp_addr.push_back(12'((r * 7 + i * 3 + 1) * 64 + r * 17 + i * 5));
        exp_data.push_back(8'h30 + 8'(r * 16 + i));
        tick();
      end
      paint = 1'b0;
      wait_idle($sformatf("t4_idle_r%0d", r), 60);
    end
    gnt_toggle = 1'b0;
    check("t4_nwrites", wq_addr.size(), 12);
    check("t4_ovf", overflow, 0);
    for (int i = 0; i < 12 && i < wq_addr.size(); i++) begin
      check($sformatf("t4_addr%0d", i), wq_addr[i], exp_addr[i]);
      check($sformatf("t4_data%0d", i), wq_data[i], exp_data[i]);
    end

    // Reset while the write strobe is high.
    wq_addr.delete(); wq_data.delete();
    mem_gnt = 1'b1;
    drive_px(5, 5, 8'hC3);
    tick();
    paint = 1'b0;
    tick();
    tick();
    check("t5_in_write", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_we", mem_we, 0);
    check("t5_rst_req", mem_req, 0);
    check("t5_rst_idle", idle, 1);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t5_no_stale", wq_addr.size(), 0);
    check("t5_idle_after", idle, 1);

    // Highest pixel, full and truncated address.
    wq_addr.delete(); wq_data.delete(); wq2_addr.delete();
    drive_px(63, 63, 8'h5A);
    tick();
    paint = 1'b0;
    check("t6_oob", oob, 0);
    tick();
    check("t6_addr12", mem_addr, 4095);
    check("t6_addr10", mem_addr2, 1023);
    wait_idle("t6_idle", 10);
    check("t6_nwrites", wq_addr.size(), 1);
    check("t6_nwrites10", wq2_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      check("t6_wr_addr", wq_addr[0], 4095);
      check("t6_wr_data", wq_data[0], 8'h5A);
    end
    if (wq2_addr.size() > 0) check("t6_wr_addr10", wq2_addr[0], 1023);
    check("t6_dut10_idle", idle2, 1);
    check("t6_dut10_req", mem_req2, 0);
    check("t6_dut10_we", mem_we2, 0);
    check("t6_dut10_full", full2, 0);
    check("t6_dut10_ovf", overflow2, 0);
    check("t6_dut10_oob", oob2, 0);
    check("t6_dut10_data", mem_wdata2, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
